key_pulse_gen: RTL and testbench
================================

# key_pulse_gen

Front-end key conditioner for the countdown timer: takes the four raw push-button levels (start/pause, reset, +1, −1), synchronises and debounces each, and emits the one-clock press pulses the countdown state machine consumes. It sits between the board pins and the countdown FSM, so all key metastability and bounce handling lives here. Optional auto-repeat makes a held +1/−1 key step the time continuously.

## Interface
Parameters:
- CLK_FREQ_HZ, 10_000_000, input clock frequency; one millisecond = CLK_FREQ_HZ/1000 cycles (integer division).
- DEBOUNCE_MS, 20, time the synchronised level must differ from the stable level before it is accepted.
- KEY_ACTIVE_LOW, 0, 1 = raw keys read 0 when pressed; internally normalised to 1 = pressed.
- REPEAT_DELAY_MS, 500, hold time from the first pulse to the first repeat pulse (auto-repeat only).
- REPEAT_RATE_MS, 100, interval between subsequent repeat pulses (auto-repeat only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- key_start_raw  in  1  raw start/pause button, asynchronous to clk.
- key_reset_raw  in  1  raw reset button.
- key_add_raw  in  1  raw +1 button.
- key_sub_raw  in  1  raw −1 button.
- start_pause_p  out  1  one-cycle press pulse.
- reset_p  out  1  one-cycle press pulse.
- add_p  out  1  one-cycle press pulse (plus repeats if enabled).
- sub_p  out  1  one-cycle press pulse (plus repeats if enabled).

## Operation
- Four identical, fully independent channels. There is no cross-key priority; the downstream FSM resolves simultaneous pulses.
- Per channel: the input is normalised (inverted if KEY_ACTIVE_LOW), then passed through a 2-FF synchroniser (sync1, sync2).
- DB_CNT = (CLK_FREQ_HZ/1000)*DEBOUNCE_MS, held in a 24-bit counter. DB_CNT = 0 is treated as 1.
- Debounce filter:
  - If sync2 == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CNT−1, stable <= sync2 and the counter clears.
  - Any glitch shorter than DB_CNT cycles therefore never reaches stable.
- Press pulse: registered, high for exactly one cycle on a 0→1 change of stable. A 1→0 change (release) produces nothing.
- Outputs are registered; no combinational path from any raw input to any output.
- Reset (async): sync FFs, stable, counters and all outputs go to 0. A key already held when rst deasserts is seen as a fresh press after DB_CNT+3 cycles.

## Timing
- A clean raw 0→1 edge that meets setup before clk edge E0 gives a pulse high in the cycle following edge E0+DB_CNT+2, i.e. latency DB_CNT+3 edges (±1 for the async input).
- Release is accepted after the same DB_CNT qualification. A new press pulse requires stable to have returned to 0 first.
- Minimum accepted press width and minimum gap between presses are both DB_CNT cycles of stable synchronised level.
- Each pulse is exactly 1 cycle wide. Two pulses on the same channel are never adjacent: the minimum spacing is 2·DB_CNT cycles.

## Configuration
- KEY_AUTOREPEAT_EN defined, add and sub channels only:
  - A per-channel repeat counter starts at the press pulse.
  - While stable stays 1, a repeat pulse fires REPEAT_DELAY_MS after the press pulse, then every REPEAT_RATE_MS.
  - Release (stable→0) or rst clears the counter immediately; no trailing pulse.
  - Holding add and sub together repeats both, in phase only if pressed together.
- KEY_AUTOREPEAT_EN undefined: no repeat logic is generated, and every channel gives exactly one pulse per debounced press regardless of hold time.
- start_pause_p and reset_p never repeat in either build.

## Test plan
Bench settings: CLK_FREQ_HZ=1000, DEBOUNCE_MS=5 (DB_CNT=5), REPEAT_DELAY_MS=20, REPEAT_RATE_MS=10.
- Reset: assert rst mid-cycle with keys idle -> all outputs 0 immediately (asynchronous), held until after deassert.
- Clean press of key_add_raw held 30 cycles, autorepeat off -> add_p high exactly 1 cycle, DB_CNT+3=8 edges after the press. Release -> no pulse.
- Bounce: key_start_raw toggles with 1–3-cycle high/low runs for 20 cycles, then settles high -> exactly one start_pause_p, 8 edges after settling. A 4-cycle glitch -> no pulse.
- Simultaneous: key_reset_raw and key_sub_raw rise on the same edge -> reset_p and sub_p pulse in the same cycle.
- KEY_ACTIVE_LOW=1: idle-high inputs after reset give no pulses; driving key_add_raw low -> one add_p.
- KEY_AUTOREPEAT_EN: hold key_add_raw for 55 cycles after its first pulse -> add_p at +0, +20, +30, +40, +50. Release at +45 -> last pulse at +40. key_start_raw held the same way -> single pulse.

Source files
------------

// File: rtl/key_pulse_gen.sv
// Synchronises, debounces and edge-detects four push-buttons into one-cycle press pulses.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat on the add/sub channels.
module key_pulse_gen #(
  parameter int unsigned CLK_FREQ_HZ     = 10_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b0,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic key_start_raw,
  input  logic key_reset_raw,
  input  logic key_add_raw,
  input  logic key_sub_raw,
  output logic start_pause_p,
  output logic reset_p,
  output logic add_p,
  output logic sub_p
);

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned DB_W       = 24;
  localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned DB_RAW     = CYC_PER_MS * DEBOUNCE_MS;
  localparam int unsigned DB_CNT     = (DB_RAW == 0) ? 1 : DB_RAW;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

  logic [NUM_KEYS-1:0] raw_norm_c;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] press_c;
  logic [NUM_KEYS-1:0] rep_fire_c;
  logic [NUM_KEYS-1:0] pulse;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  // Bit order: 0 start, 1 reset, 2 add, 3 sub; internally 1 = pressed.
  assign raw_norm_c = {key_sub_raw, key_add_raw, key_reset_raw, key_start_raw}
                      ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
  assign press_c    = stable & ~stable_q;

  // Synchroniser, edge-detect history and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      pulse    <= '0;
    end else begin
      sync1    <= raw_norm_c;
      sync2    <= sync1;
      stable_q <= stable;
      pulse    <= press_c | rep_fire_c;
    end
  end

  // Debounce: a level is accepted only after DB_CNT consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (sync2[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          stable[k] <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned KEY_ADD       = 2;
  localparam int unsigned KEY_SUB       = 3;
  localparam int unsigned REP_W         = 32;
  localparam int unsigned REP_DELAY_RAW = CYC_PER_MS * REPEAT_DELAY_MS;
  localparam int unsigned REP_RATE_RAW  = CYC_PER_MS * REPEAT_RATE_MS;
  localparam int unsigned REP_DELAY     = (REP_DELAY_RAW == 0) ? 1 : REP_DELAY_RAW;
  localparam int unsigned REP_RATE      = (REP_RATE_RAW == 0) ? 1 : REP_RATE_RAW;
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REP_RATE - 1);

  logic [REP_W-1:0]     rep_cnt [KEY_ADD:KEY_SUB];
  logic [KEY_SUB:KEY_ADD] rep_act;
  logic [KEY_SUB:KEY_ADD] rep_rate;

  always_comb begin
    rep_fire_c = '0;
    for (int unsigned c = KEY_ADD; c <= KEY_SUB; c++) begin
      rep_fire_c[c] = rep_act[c] & stable[c]
                      & (rep_cnt[c] == (rep_rate[c] ? REP_RATE_LAST : REP_DELAY_LAST));
    end
  end

  // Repeat timer restarts on each press pulse and is dropped as soon as the key releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_act  <= '0;
      rep_rate <= '0;
      for (int unsigned c = KEY_ADD; c <= KEY_SUB; c++) rep_cnt[c] <= '0;
    end else begin
      for (int unsigned c = KEY_ADD; c <= KEY_SUB; c++) begin
        if (!stable[c]) begin
          rep_act[c]  <= 1'b0;
          rep_rate[c] <= 1'b0;
          rep_cnt[c]  <= '0;
        end else if (press_c[c]) begin
          rep_act[c]  <= 1'b1;
          rep_rate[c] <= 1'b0;
          rep_cnt[c]  <= '0;
        end else if (rep_act[c]) begin
          if (rep_fire_c[c]) begin
            rep_rate[c] <= 1'b1;
            rep_cnt[c]  <= '0;
          end else begin
            rep_cnt[c] <= rep_cnt[c] + REP_W'(1);
          end
        end
      end
    end
  end
`else
  assign rep_fire_c = '0;
`endif

  assign start_pause_p = pulse[0];
  assign reset_p       = pulse[1];
  assign add_p         = pulse[2];
  assign sub_p         = pulse[3];

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: per-cycle behavioural model compare plus directed literal checks.
// Honours KEY_AUTOREPEAT_EN when defined for the build.
module tb_key_pulse_gen;

  localparam int DB = 5;
  localparam int RD = 20;
  localparam int RR = 10;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_start_raw = 1'b0, key_reset_raw = 1'b0, key_add_raw = 1'b0, key_sub_raw = 1'b0;
  logic b_start_raw = 1'b1, b_reset_raw = 1'b1, b_add_raw = 1'b1, b_sub_raw = 1'b1;
  logic start_pause_p, reset_p, add_p, sub_p;
  logic b_start_p, b_reset_p, b_add_p, b_sub_p;

  key_pulse_gen #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(5), .KEY_ACTIVE_LOW(1'b0),
                  .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(10)) dut_a (
    .clk(clk), .rst(rst),
    .key_start_raw(key_start_raw), .key_reset_raw(key_reset_raw),
    .key_add_raw(key_add_raw), .key_sub_raw(key_sub_raw),
    .start_pause_p(start_pause_p), .reset_p(reset_p), .add_p(add_p), .sub_p(sub_p));

  key_pulse_gen #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(5), .KEY_ACTIVE_LOW(1'b1),
                  .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(10)) dut_b (
    .clk(clk), .rst(rst),
    .key_start_raw(b_start_raw), .key_reset_raw(b_reset_raw),
    .key_add_raw(b_add_raw), .key_sub_raw(b_sub_raw),
    .start_pause_p(b_start_p), .reset_p(b_reset_p), .add_p(b_add_p), .sub_p(b_sub_p));

  always #5 clk = ~clk;

  // Model state per key: sampled history, accepted level, run of disagreeing samples, event times.
  typedef struct {
    bit h0;
    bit h1;
    bit acc;
    int run;
    int rise_at;
    int press_t;
  } ch_t;

  ch_t   ma[4];
  ch_t   mb[4];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    pq[4][$];
  int    bcnt[4] = '{0, 0, 0, 0};
  string nm[4] = '{"start", "reset", "add", "sub"};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
  endtask

  task automatic model_reset(output ch_t s);
    s.h0 = 1'b0; s.h1 = 1'b0; s.acc = 1'b0;
    s.run = 0; s.rise_at = -10; s.press_t = -1;
  endtask

  // One clock edge n: pulse follows one edge after acceptance of a press; repeats at
  // press+RD, press+RD+RR, ... while the accepted level is still 1.
  task automatic model_step(inout ch_t s, input bit r, input bit rep_ok, input int n,
                            output bit e);
    bit seen;
    int d;
    seen = s.h1;
    e = 1'b0;
    d = n - s.press_t;
    if (s.acc && s.rise_at == n - 1) begin
      e = 1'b1;
      s.press_t = n;
    end else if (rep_ok && s.acc && s.press_t >= 0 && d >= RD && (d - RD) % RR == 0) begin
      e = 1'b1;
    end
    if (seen != s.acc) begin
      s.run++;
      if (s.run == DB) begin
        s.acc = seen;
        s.run = 0;
        if (seen) s.rise_at = n;
        else s.press_t = -1;
      end
    end else begin
      s.run = 0;
    end
    s.h1 = s.h0;
    s.h0 = r;
  endtask

  always @(posedge clk) begin : monitor
    bit [3:0] ra, rb, ea, eb, ga, gb;
    bit e;
    ra = {key_sub_raw, key_add_raw, key_reset_raw, key_start_raw};
    rb = ~{b_sub_raw, b_add_raw, b_reset_raw, b_start_raw};
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        model_reset(ma[i]);
        model_reset(mb[i]);
        ea[i] = 1'b0;
        eb[i] = 1'b0;
      end else begin
        model_step(ma[i], ra[i], REP && i >= 2, cyc, e);
        ea[i] = e;
        model_step(mb[i], rb[i], REP && i >= 2, cyc, e);
        eb[i] = e;
      end
    end
    #1;
    ga = {sub_p, add_p, reset_p, start_pause_p};
    gb = {b_sub_p, b_add_p, b_reset_p, b_start_p};
    for (int i = 0; i < 4; i++) begin
      check({"model_a_", nm[i]}, 32'(ga[i]), 32'(ea[i]));
      check({"model_b_", nm[i]}, 32'(gb[i]), 32'(eb[i]));
      if (ga[i]) pq[i].push_back(cyc);
      if (gb[i]) bcnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) pq[i].delete();
  endtask

  task automatic check_offsets(input string name, input int base, input int exp_off[$]);
    check({name, "_count"}, 32'(pq[2].size()), 32'(exp_off.size()));
    for (int i = 0; i < exp_off.size() && i < pq[2].size(); i++)
      check({name, "_offset"}, 32'(pq[2][i] - base), 32'(exp_off[i]));
  endtask

  initial begin : stim
    int e0;
    int runs[10];
    bit lvl;
    int exp_off[$];
    runs = '{1, 2, 3, 1, 2, 1, 3, 2, 3, 2};

    // Asynchronous reset must clear outputs before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_async_a", 32'({sub_p, add_p, reset_p, start_pause_p}), 32'd0);
    check("rst_async_b", 32'({b_sub_p, b_add_p, b_reset_p, b_start_p}), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // Clean add press held 30 edges.
    clear_q();
    key_add_raw = 1'b1;
    e0 = cyc + 1;
    tick(30);
    key_add_raw = 1'b0;
    tick(20);
    check("add_clean_count", 32'(pq[2].size()), REP ? 32'd2 : 32'd1);
    if (pq[2].size() > 0) check("add_clean_latency_edges", 32'(pq[2][0] - e0 + 1), 32'd8);

    // Bouncy start key, then settle high.
    clear_q();
    lvl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_start_raw = lvl;
      tick(runs[i]);
      lvl = ~lvl;
    end
    key_start_raw = 1'b1;
    e0 = cyc + 1;
    tick(15);
    check("bounce_count", 32'(pq[0].size()), 32'd1);
    if (pq[0].size() > 0) check("bounce_latency_edges", 32'(pq[0][0] - e0 + 1), 32'd8);
    key_start_raw = 1'b0;
    tick(15);

    // Four-cycle glitch must be rejected.
    clear_q();
    key_start_raw = 1'b1;
    tick(4);
    key_start_raw = 1'b0;
    tick(15);
    check("glitch_count", 32'(pq[0].size()), 32'd0);

    // Simultaneous reset and sub presses.
    clear_q();
    key_reset_raw = 1'b1;
    key_sub_raw = 1'b1;
    tick(15);
    check("simul_reset_count", 32'(pq[1].size()), 32'd1);
    check("simul_sub_count", 32'(pq[3].size()), 32'd1);
    if (pq[1].size() > 0 && pq[3].size() > 0)
      check("simul_same_edge", 32'(pq[3][0]), 32'(pq[1][0]));
    key_reset_raw = 1'b0;
    key_sub_raw = 1'b0;
    tick(15);

    // Active-low instance: idle-high keys never pulse; one low press gives one add pulse.
    check("b_idle_pulses", 32'(bcnt[0] + bcnt[1] + bcnt[2] + bcnt[3]), 32'd0);
    b_add_raw = 1'b0;
    tick(15);
    b_add_raw = 1'b1;
    tick(15);
    check("b_add_count", 32'(bcnt[2]), 32'd1);
    check("b_total_count", 32'(bcnt[0] + bcnt[1] + bcnt[2] + bcnt[3]), 32'd1);

    // Hold add; accepted release lands at first pulse + 45.
    clear_q();
    key_add_raw = 1'b1;
    e0 = cyc + 1;
    tick(46);
    key_add_raw = 1'b0;
    tick(20);
    if (REP) exp_off = '{0, 20, 30, 40};
    else exp_off = '{0};
    check_offsets("rep_rel45", e0 + 7, exp_off);

    // Hold add for 55 edges of accepted level after the first pulse.
    clear_q();
    key_add_raw = 1'b1;
    e0 = cyc + 1;
    tick(56);
    key_add_raw = 1'b0;
    tick(20);
    if (REP) exp_off = '{0, 20, 30, 40, 50};
    else exp_off = '{0};
    check_offsets("rep_hold55", e0 + 7, exp_off);

    // Start key never repeats.
    clear_q();
    key_start_raw = 1'b1;
    tick(56);
    key_start_raw = 1'b0;
    tick(20);
    check("start_hold_count", 32'(pq[0].size()), 32'd1);

    // Reset asserted mid-pulse clears outputs at once; held key re-presses after release.
    clear_q();
    key_add_raw = 1'b1;
    tick(8);
    check("add_before_rst", 32'(add_p), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_a", 32'({sub_p, add_p, reset_p, start_pause_p}), 32'd0);
    tick(2);
    rst = 1'b0;
    clear_q();
    e0 = cyc + 1;
    tick(15);
    check("held_after_rst_count", 32'(pq[2].size()), 32'd1);
    if (pq[2].size() > 0) check("held_after_rst_latency", 32'(pq[2][0] - e0 + 1), 32'd8);
    key_add_raw = 1'b0;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
